// File: rtl/game_flow_ctrl_if.sv
// ----------------------------------------------------------------------------
// game_flow_ctrl_if
// Bundles the game-flow controller's inputs and status outputs.
//   master : the side that drives tick60/start_req/mode_2p/KO/health and
//            observes the flow status (menu logic, bench, etc.)
//   slave  : the game_flow_ctrl itself
// Signals:
//   tick60          one-clock pulse per 60 Hz frame
//   start_req       level confirm request from the menu
//   mode_2p         1 = two-player, 0 = one-player
//   p1_ko, p2_ko    player health reached zero (level)
//   p1_hp, p2_hp    current health, consulted only at round timeout
//   state           MENU=0 COUNTDOWN=1 FIGHT=2 ROUND_END=3 MATCH_END=4
//   fight_enable    high only while in FIGHT
//   countdown_digit 3/2/1 during COUNTDOWN, else 0
//   round_timer     seconds remaining in the round
//   round_num       current round, 1-based
//   p1_wins/p2_wins rounds won
//   round_winner    0 draw/none, 1 P1, 2 P2 (last finished round)
//   match_winner    0 draw/none, 1 P1, 2 P2 (valid in MATCH_END)
//   mode_latched    mode_2p captured at match start
// ----------------------------------------------------------------------------
interface game_flow_ctrl_if;
   logic       tick60;
   logic       start_req;
   logic       mode_2p;
   logic       p1_ko;
   logic       p2_ko;
   logic [6:0] p1_hp;
   logic [6:0] p2_hp;
   logic [2:0] state;
   logic       fight_enable;
   logic [1:0] countdown_digit;
   logic [6:0] round_timer;
   logic [2:0] round_num;
   logic [1:0] p1_wins;
   logic [1:0] p2_wins;
   logic [1:0] round_winner;
   logic [1:0] match_winner;
   logic       mode_latched;

   modport master (
      output tick60, start_req, mode_2p, p1_ko, p2_ko, p1_hp, p2_hp,
      input  state, fight_enable, countdown_digit, round_timer, round_num,
             p1_wins, p2_wins, round_winner, match_winner, mode_latched
   );

   modport slave (
      input  tick60, start_req, mode_2p, p1_ko, p2_ko, p1_hp, p2_hp,
      output state, fight_enable, countdown_digit, round_timer, round_num,
             p1_wins, p2_wins, round_winner, match_winner, mode_latched
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// ----------------------------------------------------------------------------
// game_flow_ctrl
// Match/round sequencer for a two-fighter game: menu -> 3-2-1 countdown ->
// fight -> round end -> (next round | match end) -> menu.
// Ports:
//   clock    system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      game_flow_ctrl_if.slave (inputs and status outputs, see there)
// Parameters:
//   COUNT_FRAMES  frames per countdown digit (1..127)
//   ROUND_SECONDS round timer load value (1..99)
//   END_FRAMES    frames held in ROUND_END / minimum hold in MATCH_END
//   WINS_NEEDED   round wins that take the match (1..3)
//   MAX_ROUNDS    round limit (1..7)
// ----------------------------------------------------------------------------
module game_flow_ctrl #(
   parameter int COUNT_FRAMES  = 60,
   parameter int ROUND_SECONDS = 99,
   parameter int END_FRAMES    = 120,
   parameter int WINS_NEEDED   = 2,
   parameter int MAX_ROUNDS    = 5
) (
   input logic             clock,
   input logic             reset_n,
   game_flow_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      MENU      = 3'd0,
      COUNTDOWN = 3'd1,
      FIGHT     = 3'd2,
      ROUND_END = 3'd3,
      MATCH_END = 3'd4
   } state_t;

   localparam logic [6:0] CNT_LAST   = 7'(COUNT_FRAMES);
   localparam logic [6:0] END_LAST   = 7'(END_FRAMES);
   localparam logic [6:0] TIMER_LOAD = 7'(ROUND_SECONDS);
   localparam logic [1:0] WINS_MAX   = 2'(WINS_NEEDED);
   localparam logic [2:0] ROUND_MAX  = 3'(MAX_ROUNDS);

   state_t     state_q, state_d;
   logic       start_prev_q;
   logic       armed_q;
   logic       start_edge;
   logic [6:0] frame_q, frame_d;
   logic [5:0] sec_q, sec_d;
   logic       hold_done_q, hold_done_d;
   logic       fight_q, fight_d;
   logic [1:0] digit_q, digit_d;
   logic [6:0] timer_q, timer_d;
   logic [2:0] round_q, round_d;
   logic [1:0] p1w_q, p1w_d;
   logic [1:0] p2w_q, p2w_d;
   logic [1:0] rwin_q, rwin_d;
   logic [1:0] mwin_q, mwin_d;
   logic       mode_q, mode_d;

   // Win counters saturate at the match-winning count.
   function automatic logic [1:0] win_inc(input logic [1:0] w);
      return (w >= WINS_MAX) ? w : w + 2'd1;
   endfunction

   // armed_q only sets once start_req has been seen low after reset, so a
   // request held high through reset release never looks like an edge.
   assign start_edge = bus.start_req & ~start_prev_q & armed_q;

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      sec_d       = sec_q;
      hold_done_d = hold_done_q;
      digit_d     = digit_q;
      timer_d     = timer_q;
      round_d     = round_q;
      p1w_d       = p1w_q;
      p2w_d       = p2w_q;
      rwin_d      = rwin_q;
      mwin_d      = mwin_q;
      mode_d      = mode_q;

      case (state_q)
         MENU: begin
            if (start_edge) begin
               state_d = COUNTDOWN;
               mode_d  = bus.mode_2p;
               p1w_d   = 2'd0;
               p2w_d   = 2'd0;
               rwin_d  = 2'd0;
               mwin_d  = 2'd0;
               round_d = 3'd1;
               digit_d = 2'd3;
               frame_d = 7'd0;
            end
         end

         COUNTDOWN: begin
            if (bus.tick60) begin
               if (frame_q + 7'd1 == CNT_LAST) begin
                  frame_d = 7'd0;
                  if (digit_q == 2'd1) begin
                     state_d = FIGHT;
                     timer_d = TIMER_LOAD;
                     digit_d = 2'd0;
                     sec_d   = 6'd0;
                  end else begin
                     digit_d = digit_q - 2'd1;
                  end
               end else begin
                  frame_d = frame_q + 7'd1;
               end
            end
         end

         FIGHT: begin
            // One game second is always 60 frames.
            if (bus.tick60) begin
               if (sec_q == 6'd59) begin
                  sec_d = 6'd0;
                  if (timer_q != 7'd0) timer_d = timer_q - 7'd1;
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
            // KO outranks a timeout seen on the same clock.
            if (bus.p1_ko || bus.p2_ko) begin
               state_d = ROUND_END;
               frame_d = 7'd0;
               if (bus.p1_ko && bus.p2_ko) begin
                  rwin_d = 2'd0;
               end else if (bus.p1_ko) begin
                  rwin_d = 2'd2;
                  p2w_d  = win_inc(p2w_q);
               end else begin
                  rwin_d = 2'd1;
                  p1w_d  = win_inc(p1w_q);
               end
            end else if (timer_q == 7'd0) begin
               state_d = ROUND_END;
               frame_d = 7'd0;
               if (bus.p1_hp > bus.p2_hp) begin
                  rwin_d = 2'd1;
                  p1w_d  = win_inc(p1w_q);
               end else if (bus.p2_hp > bus.p1_hp) begin
                  rwin_d = 2'd2;
                  p2w_d  = win_inc(p2w_q);
               end else begin
                  rwin_d = 2'd0;
               end
            end
         end

         ROUND_END: begin
            if (bus.tick60) begin
               if (frame_q + 7'd1 == END_LAST) begin
                  frame_d = 7'd0;
                  if (p1w_q == WINS_MAX || p2w_q == WINS_MAX || round_q == ROUND_MAX) begin
                     state_d     = MATCH_END;
                     hold_done_d = 1'b0;
                     if (p1w_q > p2w_q)      mwin_d = 2'd1;
                     else if (p2w_q > p1w_q) mwin_d = 2'd2;
                     else                    mwin_d = 2'd0;
                  end else begin
                     state_d = COUNTDOWN;
                     round_d = round_q + 3'd1;
                     digit_d = 2'd3;
                  end
               end else begin
                  frame_d = frame_q + 7'd1;
               end
            end
         end

         MATCH_END: begin
            // Confirm requests are ignored until the results screen has been
            // shown for the full hold time.
            if (!hold_done_q) begin
               if (bus.tick60) begin
                  if (frame_q + 7'd1 == END_LAST) begin
                     hold_done_d = 1'b1;
                     frame_d     = 7'd0;
                  end else begin
                     frame_d = frame_q + 7'd1;
                  end
               end
            end else if (start_edge) begin
               state_d = MENU;
               frame_d = 7'd0;
            end
         end

         default: state_d = MENU;
      endcase

      fight_d = (state_d == FIGHT);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= MENU;
         start_prev_q <= 1'b0;
         armed_q      <= 1'b0;
         frame_q      <= 7'd0;
         sec_q        <= 6'd0;
         hold_done_q  <= 1'b0;
         fight_q      <= 1'b0;
         digit_q      <= 2'd0;
         timer_q      <= TIMER_LOAD;
         round_q      <= 3'd1;
         p1w_q        <= 2'd0;
         p2w_q        <= 2'd0;
         rwin_q       <= 2'd0;
         mwin_q       <= 2'd0;
         mode_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= bus.start_req;
         armed_q      <= armed_q | ~bus.start_req;
         frame_q      <= frame_d;
         sec_q        <= sec_d;
         hold_done_q  <= hold_done_d;
         fight_q      <= fight_d;
         digit_q      <= digit_d;
         timer_q      <= timer_d;
         round_q      <= round_d;
         p1w_q        <= p1w_d;
         p2w_q        <= p2w_d;
         rwin_q       <= rwin_d;
         mwin_q       <= mwin_d;
         mode_q       <= mode_d;
      end
   end

   assign bus.state           = state_q;
   assign bus.fight_enable    = fight_q;
   assign bus.countdown_digit = digit_q;
   assign bus.round_timer     = timer_q;
   assign bus.round_num       = round_q;
   assign bus.p1_wins         = p1w_q;
   assign bus.p2_wins         = p2w_q;
   assign bus.round_winner    = rwin_q;
   assign bus.match_winner    = mwin_q;
   assign bus.mode_latched    = mode_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed bench for game_flow_ctrl with default parameters: a table of
// {inputs, tick count, expected outputs} walks a full 2-0 match, then
// hand-written sequences cover draws, KO at timeout, hp timeout, the
// five-draw match, MATCH_END hold and reset with start_req held high.
// Expected outputs are packed as
// {state, fight_enable, digit, timer, round, p1_wins, p2_wins, rwin, mwin, mode}.
// ----------------------------------------------------------------------------
module tb_game_flow_ctrl;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   game_flow_ctrl_if bus();

   game_flow_ctrl dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic        start;
      logic        mode;
      logic        ko1;
      logic        ko2;
      int          nticks;
      logic [24:0] exp;
   } vec_t;

   vec_t vecs[16];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [24:0] pk(input int st, input int fe, input int dg,
                                      input int tm, input int rn, input int w1,
                                      input int w2, input int rw, input int mw,
                                      input int ml);
      return {st[2:0], fe[0], dg[1:0], tm[6:0], rn[2:0], w1[1:0], w2[1:0],
              rw[1:0], mw[1:0], ml[0]};
   endfunction

   function automatic logic [24:0] outs();
      return {bus.state, bus.fight_enable, bus.countdown_digit, bus.round_timer,
              bus.round_num, bus.p1_wins, bus.p2_wins, bus.round_winner,
              bus.match_winner, bus.mode_latched};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clock);
      #1;
   endtask

   // Each frame tick is a one-clock pulse followed by an idle clock.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick60 = 1'b1;
         clk1();
         bus.tick60 = 1'b0;
         clk1();
      end
   endtask

   task automatic pulse_start();
      bus.start_req = 1'b1;
      clk1();
      bus.start_req = 1'b0;
      clk1();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0,   pk(1,0,3,99,1,0,0,0,0,1)};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 59,  pk(1,0,3,99,1,0,0,0,0,1)};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,   pk(1,0,2,99,1,0,0,0,0,1)};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 60,  pk(1,0,1,99,1,0,0,0,0,1)};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 59,  pk(1,0,1,99,1,0,0,0,0,1)};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,   pk(2,1,0,99,1,0,0,0,0,1)};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 60,  pk(2,1,0,98,1,0,0,0,0,1)};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0,   pk(3,0,0,98,1,1,0,1,0,1)};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 119, pk(3,0,0,98,1,1,0,1,0,1)};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,   pk(1,0,3,98,2,1,0,1,0,1)};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 180, pk(2,1,0,99,2,1,0,1,0,1)};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,   pk(3,0,0,99,2,2,0,1,0,1)};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 120, pk(4,0,0,99,2,2,0,1,1,1)};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 120, pk(4,0,0,99,2,2,0,1,1,1)};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   pk(0,0,0,99,2,2,0,1,1,1)};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   pk(0,0,0,99,2,2,0,1,1,1)};

      reset_n       = 1'b0;
      bus.tick60    = 1'b0;
      bus.start_req = 1'b0;
      bus.mode_2p   = 1'b0;
      bus.p1_ko     = 1'b0;
      bus.p2_ko     = 1'b0;
      bus.p1_hp     = 7'd100;
      bus.p2_hp     = 7'd100;
      repeat (3) clk1();
      reset_n = 1'b1;
      clk1();
      check("reset_values", 32'(outs()), 32'(pk(0,0,0,99,1,0,0,0,0,0)));

      // Table: full match won 2-0 by P1 through KOs.
      for (int i = 0; i < 16; i++) begin
         bus.start_req = vecs[i].start;
         bus.mode_2p   = vecs[i].mode;
         bus.p1_ko     = vecs[i].ko1;
         bus.p2_ko     = vecs[i].ko2;
         if (vecs[i].nticks == 0) clk1();
         else ticks(vecs[i].nticks);
         checks++;
         if (outs() !== vecs[i].exp) begin
            failures++;
            $display("FAIL vec%0d: got %h expected %h", i, outs(), vecs[i].exp);
         end
      end
      bus.p1_ko = 1'b0;
      bus.p2_ko = 1'b0;

      // Double KO is a draw; counters stay clear.
      bus.mode_2p = 1'b1;
      pulse_start();
      check("restart_state", 32'(bus.state), 32'd1);
      check("restart_wins", 32'({bus.p1_wins, bus.p2_wins, bus.match_winner}), 32'd0);
      ticks(180);
      bus.p1_ko = 1'b1;
      bus.p2_ko = 1'b1;
      clk1();
      bus.p1_ko = 1'b0;
      bus.p2_ko = 1'b0;
      check("dko_state", 32'(bus.state), 32'd3);
      check("dko_result", 32'({bus.round_winner, bus.p1_wins, bus.p2_wins}), 32'd0);
      ticks(120);
      check("dko_next_round", 32'(bus.round_num), 32'd2);
      ticks(180);

      // KO on the very tick the timer reaches 0, equal hp: KO decides.
      bus.p1_hp = 7'd50;
      bus.p2_hp = 7'd50;
      ticks(5939);
      check("timer_one_left", 32'(bus.round_timer), 32'd1);
      bus.tick60 = 1'b1;
      bus.p1_ko  = 1'b1;
      clk1();
      bus.tick60 = 1'b0;
      bus.p1_ko  = 1'b0;
      check("ko_at_zero_state", 32'(bus.state), 32'd3);
      check("ko_at_zero_timer", 32'(bus.round_timer), 32'd0);
      check("ko_at_zero_winner", 32'(bus.round_winner), 32'd2);
      check("ko_at_zero_p2w", 32'(bus.p2_wins), 32'd1);

      // Timeout with P2 ahead on health.
      ticks(120);
      check("round3_state", 32'(bus.state), 32'd1);
      check("round3_num", 32'(bus.round_num), 32'd3);
      ticks(180);
      bus.p1_hp = 7'd40;
      bus.p2_hp = 7'd55;
      ticks(5940);
      check("timeout_state", 32'(bus.state), 32'd3);
      check("timeout_timer", 32'(bus.round_timer), 32'd0);
      check("timeout_winner", 32'(bus.round_winner), 32'd2);
      check("timeout_p2w", 32'(bus.p2_wins), 32'd2);
      ticks(120);
      check("p2_match_state", 32'(bus.state), 32'd4);
      check("p2_match_winner", 32'(bus.match_winner), 32'd2);

      // Five drawn rounds in one-player mode.
      ticks(120);
      pulse_start();
      check("back_to_menu", 32'(bus.state), 32'd0);
      bus.mode_2p = 1'b0;
      pulse_start();
      check("mode1p_latched", 32'(bus.mode_latched), 32'd0);
      bus.mode_2p = 1'b1;
      bus.p1_hp   = 7'd60;
      bus.p2_hp   = 7'd60;
      for (int r = 1; r <= 5; r++) begin
         ticks(180);
         check($sformatf("draw_r%0d_fight", r), 32'({bus.state, bus.round_num}), 32'({3'd2, 3'(r)}));
         if (r == 1) begin
            ticks(5940);
         end else begin
            bus.p1_ko = 1'b1;
            bus.p2_ko = 1'b1;
            clk1();
            bus.p1_ko = 1'b0;
            bus.p2_ko = 1'b0;
         end
         check($sformatf("draw_r%0d_result", r),
               32'({bus.state, bus.round_winner, bus.p1_wins, bus.p2_wins}), 32'({3'd3, 6'd0}));
         ticks(120);
         if (r < 5)
            check($sformatf("draw_r%0d_next", r), 32'({bus.state, bus.round_num}), 32'({3'd1, 3'(r + 1)}));
         else
            check("draw_match_end", 32'({bus.state, bus.match_winner, bus.mode_latched}), 32'({3'd4, 2'd0, 1'b0}));
      end

      // Request raised at tick 50 and held: ignored, no retrigger later.
      ticks(50);
      bus.start_req = 1'b1;
      ticks(80);
      check("hold_ignores_start", 32'(bus.state), 32'd4);
      bus.start_req = 1'b0;
      clk1();
      bus.start_req = 1'b1;
      clk1();
      check("late_edge_to_menu", 32'(bus.state), 32'd0);
      bus.start_req = 1'b0;
      clk1();

      // Reset mid-fight with start_req high.
      pulse_start();
      ticks(180);
      check("pre_reset_fight", 32'(bus.fight_enable), 32'd1);
      bus.start_req = 1'b1;
      reset_n       = 1'b0;
      repeat (2) clk1();
      check("midfight_reset", 32'(outs()), 32'(pk(0,0,0,99,1,0,0,0,0,0)));
      reset_n = 1'b1;
      repeat (3) clk1();
      check("held_start_no_match", 32'(bus.state), 32'd0);
      bus.start_req = 1'b0;
      clk1();
      bus.start_req = 1'b1;
      clk1();
      check("fresh_edge_starts", 32'(bus.state), 32'd1);
      bus.start_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter COUNT_FRAMES, default 60, frames per countdown digit (1..127).
REQ-002 SHALL have parameter ROUND_SECONDS, default 99, round timer load value (1..99).
REQ-003 SHALL have parameter END_FRAMES, default 120, frames held in ROUND_END and minimum hold in MATCH_END (1..127).
REQ-004 SHALL have parameter WINS_NEEDED, default 2, round wins to take the match (1..3).
REQ-005 SHALL have parameter MAX_ROUNDS, default 5, round limit (1..7).
REQ-006 clock  in  1  system clock; all logic rising-edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 tick60  in  1  one-clock pulse per 60 Hz frame; all frame/second counters advance only on it.
REQ-009 start_req  in  1  level confirm request from the menu; rising edge detected internally.
REQ-010 mode_2p  in  1  1 = two-player, 0 = one-player; sampled only on leaving MENU.
REQ-011 p1_ko, p2_ko  in  1 each  level, player health reached zero.
REQ-012 p1_hp, p2_hp  in  7 each  current health, used only at timeout.
REQ-013 state  out  3  MENU=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_END=4.
REQ-014 fight_enable  out  1  high only in FIGHT; gates player/physics logic.
REQ-015 countdown_digit  out  2  3/2/1 during COUNTDOWN, else 0.
REQ-016 round_timer  out  7  seconds remaining.
REQ-017 round_num  out  3  current round, 1-based.
REQ-018 p1_wins, p2_wins  out  2 each  rounds won.
REQ-019 round_winner  out  2  0 none/draw, 1 P1, 2 P2; last finished round.
REQ-020 match_winner  out  2  0 none/draw, 1 P1, 2 P2; valid in MATCH_END.
REQ-021 mode_latched  out  1  mode_2p captured at match start.

Function
REQ-022 SHALL register start_req every clock; edge = current high and previous low.
REQ-023 MENU: on start_req edge SHALL go to COUNTDOWN next clock, latch mode_2p, clear wins/winners, round_num=1, countdown_digit=3, frame counter=0.
REQ-024 COUNTDOWN: frame counter SHALL increment per tick60; on reaching COUNT_FRAMES, clear and decrement digit; decrement from 1 SHALL instead enter FIGHT with round_timer=ROUND_SECONDS, digit=0, counter=0.
REQ-025 FIGHT: frame counter SHALL count tick60; every 60th tick round_timer decrements by 1, saturating at 0.
REQ-026 FIGHT KO check every clock: p1_ko only -> round_winner=2, p2_wins+1; p2_ko only -> round_winner=1, p1_wins+1; both same clock -> draw, no increment; any KO -> ROUND_END next clock.
REQ-027 FIGHT timeout (round_timer==0, no KO): higher hp wins round, equal hp draw; -> ROUND_END. KO SHALL take priority over timeout on the same clock.
REQ-028 Win counters SHALL never exceed WINS_NEEDED.
REQ-029 ROUND_END: hold END_FRAMES ticks; then if either wins==WINS_NEEDED or round_num==MAX_ROUNDS -> MATCH_END, else round_num+1, digit=3 -> COUNTDOWN.
REQ-030 MATCH_END entry: match_winner = player with more wins, equal -> 0.
REQ-031 MATCH_END: start_req edges SHALL be ignored until END_FRAMES ticks elapsed; first edge afterwards -> MENU; held-high start_req SHALL NOT retrigger.
REQ-032 fight_enable SHALL be a registered decode of state, asserted the same clock state becomes FIGHT.
REQ-033 mode_2p changes outside MENU SHALL have no effect.

Reset
REQ-034 reset_n low at a rising edge SHALL, from any state: state=MENU, fight_enable=0, countdown_digit=0, round_timer=ROUND_SECONDS, round_num=1, wins=0, round_winner=0, match_winner=0, mode_latched=0, counters and start_req history cleared.
REQ-035 start_req held high through reset release SHALL NOT start a match.

Verification
REQ-036 Reset, mode_2p=1, start_req pulse -> COUNTDOWN, mode_latched=1, digit 3 then 2/1 after 60/120 ticks, FIGHT after 180 ticks, round_timer=99.
REQ-037 FIGHT, p2_ko high -> ROUND_END next clock, round_winner=1, p1_wins=1; after 120 ticks COUNTDOWN, round_num=2; repeat -> MATCH_END, match_winner=1.
REQ-038 FIGHT, p1_ko and p2_ko same clock -> draw, wins unchanged; KO on the clock round_timer hits 0 -> KO result used.
REQ-039 No KO for 5940 ticks, p1_hp=40, p2_hp=55 -> round_timer=0, round_winner=2; equal hp -> draw.
REQ-040 Five consecutive draws -> MATCH_END after round 5, match_winner=0; start_req edge at tick 50 ignored, at tick 130 -> MENU.
REQ-041 reset_n low mid-FIGHT with start_req high -> all outputs at reset values, stays in MENU until start_req low then high.
